ext_mem_arb: RTL and testbench
==============================

# ext_mem_arb

Round-robin arbiter and sequencer that shares one reg_native-style external memory port between `NUM_REQ` requesters. Each requester issues single read or write commands over its own req/ack handshake. The arbiter grants one command at a time, runs the full downstream req/ack sequence with a timeout, and returns read data and an error flag to the granted requester only. It sits between register-access masters and a single external memory or slave block.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8
- `DATA_WIDTH`, 32: data width
- `ADDR_WIDTH`, 6: address width
- `TIMEOUT`, 16: max cycles from downstream request issue to ack, 2..255

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `s_req_vld`  in  NUM_REQ  per-requester command valid
- `s_req_rdy`  out  NUM_REQ  per-requester command accept (combinational)
- `s_wr_en`, `s_rd_en`  in  NUM_REQ each  per-requester command type
- `s_addr`  in  NUM_REQ*ADDR_WIDTH  packed; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `s_wr_data`  in  NUM_REQ*DATA_WIDTH  packed, same scheme
- `s_rd_data`  out  DATA_WIDTH  response data, shared
- `s_err`  out  1  response error flag, shared
- `s_ack_vld`  out  NUM_REQ  per-requester response valid, one-hot or zero
- `s_ack_rdy`  in  NUM_REQ  per-requester response accept
- `m_req_vld`, `m_req_rdy`  out/in  1  downstream request handshake
- `m_wr_en`, `m_rd_en`  out  1  downstream command type
- `m_addr`, `m_wr_data`  out  ADDR_WIDTH / DATA_WIDTH  downstream command
- `m_rd_data`  in  DATA_WIDTH  downstream read data, valid with `m_ack_vld`
- `m_ack_vld`, `m_ack_rdy`  in/out  1  downstream ack handshake

## Operation
- Four-state FSM:
  - IDLE: arbitrate among asserted `s_req_vld`.
  - REQ: drive `m_req_vld`.
  - WAIT_ACK: wait for the downstream ack.
  - RESP: hold `s_ack_vld[g]`.
- Arbitration is round-robin. The priority pointer resets to 0. After a grant to i, the highest priority moves to (i+1) mod NUM_REQ.
- Accept: `s_req_rdy[i]` = (state==IDLE) & grant[i], where grant is the one-hot round-robin pick. On that edge the arbiter latches g, wr_en, rd_en, addr and wr_data into internal registers. Requesters hold their command stable until accepted.
- Invalid command (wr_en==rd_en): accept, skip downstream, go to RESP with `s_err`=1 and `s_rd_data`=0.
- Valid command: IDLE→REQ. `m_req_vld`=1 and the latched command is driven on the m_* bus. The transfer completes on the edge where `m_req_vld & m_req_rdy`; then go to WAIT_ACK. Outside REQ, `m_req_vld`=0 and `m_wr_en`=`m_rd_en`=0.
- WAIT_ACK: on `m_ack_vld`, capture `m_rd_data` for reads or 0 for writes, set err=0, go to RESP.
- `m_ack_rdy` is 1 in every state except RESP. Acks seen outside WAIT_ACK (stale or late) are consumed and discarded.
- Timeout: an 8-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT_ACK. When it reaches TIMEOUT-1 without the ack, go to RESP with err=1 and rd_data=0. The transfer is abandoned.
- RESP: `s_ack_vld[g]`=1 and `s_rd_data`/`s_err` are stable. On `s_ack_rdy[g]`, go to IDLE and advance the pointer.
- Reset mid-operation: return to IDLE, pointer=0, and drop the in-flight command. No response is issued.

## Timing
- Reset values:
  - `m_req_vld`, `m_wr_en`, `m_rd_en`: 0
  - `m_addr`, `m_wr_data`: 0
  - `s_ack_vld`: 0
  - `s_rd_data`, `s_err`: 0
  - `m_ack_rdy`: 1
  - `s_req_rdy`: 0 until `s_req_vld` is seen in IDLE
- Accept at edge T0 → `m_req_vld`=1 from T0 until the m_req handshake edge.
- Ack at edge Ta → `s_ack_vld[g]`=1 from Ta.
- Minimum turnaround: accept → response visible 2 cycles later (m_req_rdy=1, ack one cycle later).
- After `s_ack_rdy` at edge Tr, the FSM is in IDLE. A new accept can occur at Tr+1, so at most one command is in flight.
- Only one `s_ack_vld` bit is ever high. `s_req_rdy` and `s_ack_vld` are never both high for the same requester.

## Test plan
- Single read, requester 0, addr 0x05, memory model holds 0xDEADBEEF:
  - `m_req_vld` with `m_rd_en`=1 and `m_addr`=0x05.
  - `s_ack_vld`=2'b01, `s_rd_data`=0xDEADBEEF, `s_err`=0.
- Write then read, requester 1, addr 0x3F, data 0x12345678: read returns 0x12345678, err=0.
- Both requesters hold `s_req_vld` for 4 back-to-back commands: grants go 0,1,0,1. Exactly one `s_ack_vld` bit is high at a time.
- Slave never acks, TIMEOUT=16: `s_ack_vld[g]` rises 16 cycles after entering REQ with err=1 and rd_data=0. A late `m_ack_vld` while IDLE is discarded.
- Command with wr_en=rd_en=1: no `m_req_vld` pulse, immediate err=1 response.
- `rst` asserted in WAIT_ACK:
  - All outputs return to reset values asynchronously and no `s_ack_vld` is issued.
  - The next grant goes to requester 0.

Source files
------------

// File: rtl/ext_mem_arb.sv
// ext_mem_arb
//   Shares one req/ack style external memory port between NUM_REQ
//   requesters. A round-robin pick selects one command at a time; the
//   command is latched, run through the downstream request/ack sequence
//   with a timeout, and the response is returned to that requester only.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   s_req_vld/s_req_rdy      per-requester command handshake (rdy is comb)
//   s_wr_en, s_rd_en         per-requester command type
//   s_addr, s_wr_data        packed per-requester command fields
//   s_rd_data, s_err         shared response data / error flag
//   s_ack_vld/s_ack_rdy      per-requester response handshake
//   m_req_vld/m_req_rdy      downstream request handshake
//   m_wr_en, m_rd_en         downstream command type
//   m_addr, m_wr_data        downstream command fields
//   m_rd_data                downstream read data, valid with m_ack_vld
//   m_ack_vld/m_ack_rdy      downstream ack handshake
module ext_mem_arb #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            s_req_vld,
  output logic [NUM_REQ-1:0]            s_req_rdy,
  input  logic [NUM_REQ-1:0]            s_wr_en,
  input  logic [NUM_REQ-1:0]            s_rd_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_wr_data,
  output logic [DATA_WIDTH-1:0]         s_rd_data,
  output logic                          s_err,
  output logic [NUM_REQ-1:0]            s_ack_vld,
  input  logic [NUM_REQ-1:0]            s_ack_rdy,
  output logic                          m_req_vld,
  input  logic                          m_req_rdy,
  output logic                          m_wr_en,
  output logic                          m_rd_en,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [DATA_WIDTH-1:0]         m_wr_data,
  input  logic [DATA_WIDTH-1:0]         m_rd_data,
  input  logic                          m_ack_vld,
  output logic                          m_ack_rdy
);

  localparam int         GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         ptr_q, ptr_d;
  logic [GW-1:0]         gnt_q, gnt_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    mask_s, hi_s, cand_s, grant_s;
  logic [GW-1:0]         gidx_s;
  logic                  sel_wr_s, sel_rd_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [GW-1:0]         ptr_next_s;
  logic                  in_req_s;

  // Round-robin pick: lowest requester at or above the pointer, else wrap
  // to the lowest requester overall. cand & -cand isolates the lowest bit.
  always_comb begin
    mask_s      = '0;
    gidx_s      = '0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask_s[i] = (GW'(i) >= ptr_q);
    end
    hi_s    = s_req_vld & mask_s;
    cand_s  = (hi_s != '0) ? hi_s : s_req_vld;
    grant_s = cand_s & (~cand_s + NUM_REQ'(1));
    for (int i = 0; i < NUM_REQ; i++) begin
      gidx_s      = gidx_s | (grant_s[i] ? GW'(i) : '0);
      sel_addr_s  = sel_addr_s | (grant_s[i] ? s_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : '0);
      sel_wdata_s = sel_wdata_s | (grant_s[i] ? s_wr_data[i*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
    sel_wr_s = |(grant_s & s_wr_en);
    sel_rd_s = |(grant_s & s_rd_en);
  end

  assign ptr_next_s = (gnt_q == GW'(NUM_REQ - 1)) ? '0 : gnt_q + GW'(1);

  // Sequencer next state: accept, downstream request, ack wait, response
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s != '0) begin
          gnt_d   = gidx_s;
          wr_d    = sel_wr_s;
          rd_d    = sel_rd_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          if (sel_wr_s == sel_rd_s) begin
            // Neither or both types set: answer with an error, no transfer
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_REQ;
            cnt_d   = 8'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (m_req_rdy) begin
          state_d = ST_WAIT;
        end else if (cnt_q >= TO_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (m_ack_vld) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = rd_q ? m_rd_data : '0;
        end else if (cnt_q >= TO_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (s_ack_rdy[gnt_q]) begin
          state_d = ST_IDLE;
          ptr_d   = ptr_next_s;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched command/response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response valid goes only to the latched requester while in RESP
  always_comb begin
    s_ack_vld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_ack_vld[i] = (state_q == ST_RESP) && (gnt_q == GW'(i));
    end
  end

  // Downstream command is only presented in REQ; zero elsewhere
  assign in_req_s  = (state_q == ST_REQ);
  assign m_req_vld = in_req_s;
  assign m_wr_en   = in_req_s & wr_q;
  assign m_rd_en   = in_req_s & rd_q;
  assign m_addr    = in_req_s ? addr_q : '0;
  assign m_wr_data = in_req_s ? wdata_q : '0;
  assign m_ack_rdy = (state_q != ST_RESP);

  assign s_req_rdy = (state_q == ST_IDLE) ? grant_s : '0;
  assign s_rd_data = rdata_q;
  assign s_err     = err_q;

endmodule

// File: tb/tb_ext_mem_arb.sv
// tb_ext_mem_arb
//   Directed bench for ext_mem_arb with a behavioural model: per-requester
//   command queues, a round-robin pointer and a reference memory predict
//   which requester is served next and what it must get back.
module tb_ext_mem_arb;

  localparam int NUM_REQ = 2;
  localparam int DW      = 32;
  localparam int AW      = 6;
  localparam int TO      = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    s_req_vld, s_req_rdy, s_wr_en, s_rd_en;
  logic [NUM_REQ*AW-1:0] s_addr;
  logic [NUM_REQ*DW-1:0] s_wr_data;
  logic [DW-1:0]         s_rd_data;
  logic                  s_err;
  logic [NUM_REQ-1:0]    s_ack_vld, s_ack_rdy;
  logic                  m_req_vld, m_req_rdy, m_wr_en, m_rd_en;
  logic [AW-1:0]         m_addr;
  logic [DW-1:0]         m_wr_data, m_rd_data;
  logic                  m_ack_vld, m_ack_rdy;

  ext_mem_arb #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_wr_en(s_wr_en), .s_rd_en(s_rd_en),
    .s_addr(s_addr), .s_wr_data(s_wr_data), .s_rd_data(s_rd_data), .s_err(s_err),
    .s_ack_vld(s_ack_vld), .s_ack_rdy(s_ack_rdy),
    .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
    .m_addr(m_addr), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
    .m_ack_vld(m_ack_vld), .m_ack_rdy(m_ack_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t          drv_q[NUM_REQ][$];
  cmd_t          mdl_q[NUM_REQ][$];
  logic [DW-1:0] slv_mem[64];
  logic [DW-1:0] ref_mem[64];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit no_ack = 1'b0;
  bit late_ack = 1'b0;
  int mptr = 0;
  int resp_count = 0;
  int grant_log[$];
  int last_g = -1;
  logic [DW-1:0] last_data;
  logic last_err;
  logic [NUM_REQ-1:0] last_vec;
  int acc_edge = 0, req_edge = 0, ack_edge = 0, mreq_count = 0;
  logic [AW-1:0] last_m_addr;
  logic last_m_rd;
  bit ack_prev = 1'b0, mvld_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic enq(input int r, input logic wr, input logic rd,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.wr = wr; c.rd = rd; c.addr = a; c.data = d;
    drv_q[r].push_back(c);
    mdl_q[r].push_back(c);
  endtask

  task automatic wait_resp(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (resp_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (resp_count < target) chk({name, "_resp_timeout"}, 64'(resp_count), 64'(target));
    @(negedge clk);
  endtask

  function automatic int glog(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return -1;
  endfunction

  // Model: next requester served is the first with a pending command,
  // searching from the round-robin pointer.
  function automatic int pick();
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (mptr + k) % NUM_REQ;
      if (mdl_q[i].size() > 0) return i;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int g);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Requester drivers: hold each command until accepted, then present the next
  initial begin
    bit acc[NUM_REQ];
    s_req_vld = '0; s_wr_en = '0; s_rd_en = '0; s_addr = '0; s_wr_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) acc[i] = s_req_vld[i] & s_req_rdy[i] & ~rst;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rst) begin
          s_req_vld[i] = 1'b0;
        end else begin
          if (acc[i]) begin
            if (drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            s_req_vld[i] = 1'b0;
          end
          if (!s_req_vld[i] && drv_q[i].size() > 0) begin
            s_wr_en[i]               = drv_q[i][0].wr;
            s_rd_en[i]               = drv_q[i][0].rd;
            s_addr[i*AW +: AW]       = drv_q[i][0].addr;
            s_wr_data[i*DW +: DW]    = drv_q[i][0].data;
            s_req_vld[i]             = 1'b1;
          end
        end
      end
    end
  end

  // Downstream slave: always ready, acks one cycle after the request handshake
  initial begin
    logic [DW-1:0] rd_val;
    bit due;
    m_req_rdy = 1'b1; m_ack_vld = 1'b0; m_rd_data = '0; due = 1'b0; rd_val = '0;
    forever begin
      @(negedge clk);
      m_ack_vld = 1'b0;
      if (rst) begin
        due = 1'b0;
      end else if (due) begin
        m_ack_vld = 1'b1; m_rd_data = rd_val; due = 1'b0;
      end else if (late_ack) begin
        m_ack_vld = 1'b1; m_rd_data = 32'hFACE_FACE; late_ack = 1'b0;
      end
      if (!rst && m_req_vld && m_req_rdy) begin
        if (m_wr_en) slv_mem[m_addr] = m_wr_data;
        rd_val = m_rd_en ? slv_mem[m_addr] : 32'hBAD0_BAD0;
        due = !no_ack;
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    int g;
    cmd_t c;
    logic exp_err;
    logic [DW-1:0] exp_data;
    if (rst) begin
      mptr = 0; ack_prev = 1'b0; mvld_prev = 1'b0;
    end else begin
      g = pick();
      chk("ack_onehot0", 64'($onehot0(s_ack_vld)), 64'd1);
      chk("rdy_ack_overlap", 64'(s_req_rdy & s_ack_vld), 64'd0);
      chk("m_ack_rdy", 64'(m_ack_rdy), 64'(s_ack_vld == '0));
      if (s_req_rdy != '0) begin
        chk("accept_grant", 64'(s_req_rdy), 64'(onehot(g)));
        if (s_req_rdy & s_req_vld) acc_edge = cyc + 1;
      end
      if (m_req_vld) begin
        if (!mvld_prev) begin req_edge = cyc; mreq_count++; end
        last_m_addr = m_addr; last_m_rd = m_rd_en;
        if (g < 0) begin
          chk("m_req_unexpected", 64'd1, 64'd0);
        end else begin
          c = mdl_q[g][0];
          chk("m_cmd", {24'd0, m_wr_en, m_rd_en, m_addr, (m_wr_en ? m_wr_data : 32'd0)},
                       {24'd0, c.wr, c.rd, c.addr, (c.wr ? c.data : 32'd0)});
        end
      end else begin
        chk("m_idle_type", 64'({m_wr_en, m_rd_en}), 64'd0);
      end
      if (s_ack_vld != '0) begin
        if (!ack_prev) ack_edge = cyc;
        if (g < 0) begin
          chk("resp_unexpected", 64'(s_ack_vld), 64'd0);
        end else begin
          c = mdl_q[g][0];
          if (c.wr == c.rd || no_ack) begin
            exp_err = 1'b1; exp_data = '0;
          end else begin
            exp_err = 1'b0; exp_data = c.rd ? ref_mem[c.addr] : '0;
          end
          chk("resp_vld", 64'(s_ack_vld), 64'(onehot(g)));
          chk("resp_data", 64'(s_rd_data), 64'(exp_data));
          chk("resp_err", 64'(s_err), 64'(exp_err));
          if (s_ack_rdy[g]) begin
            if (c.wr && !c.rd && !no_ack) ref_mem[c.addr] = c.data;
            void'(mdl_q[g].pop_front());
            mptr = (g + 1) % NUM_REQ;
            resp_count++;
            grant_log.push_back(g);
            last_g = g; last_data = s_rd_data; last_err = s_err; last_vec = s_ack_vld;
          end
        end
      end
      ack_prev  = (s_ack_vld != '0);
      mvld_prev = m_req_vld;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mc;
    int n;
    rst = 1'b1;
    s_ack_rdy = '1;
    for (int i = 0; i < 64; i++) begin
      slv_mem[i] = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    slv_mem[5] = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_req_vld", 64'(m_req_vld), 64'd0);
    chk("rst_m_type", 64'({m_wr_en, m_rd_en}), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_wr_data", 64'(m_wr_data), 64'd0);
    chk("rst_s_ack_vld", 64'(s_ack_vld), 64'd0);
    chk("rst_s_rd_data", 64'(s_rd_data), 64'd0);
    chk("rst_s_err", 64'(s_err), 64'd0);
    chk("rst_m_ack_rdy", 64'(m_ack_rdy), 64'd1);
    chk("rst_s_req_rdy", 64'(s_req_rdy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single read from requester 0
    enq(0, 1'b0, 1'b1, 6'h05, 32'd0);
    wait_resp(1, 50, "t1");
    chk("t1_grant", 64'(last_g), 64'd0);
    chk("t1_vec", 64'(last_vec), 64'h1);
    chk("t1_data", 64'(last_data), 64'hDEAD_BEEF);
    chk("t1_err", 64'(last_err), 64'd0);
    chk("t1_m_addr", 64'(last_m_addr), 64'h05);
    chk("t1_m_rd", 64'(last_m_rd), 64'd1);
    chk("t1_req_at_accept", 64'(req_edge - acc_edge), 64'd0);
    chk("t1_turnaround", 64'(ack_edge - acc_edge), 64'd2);

    // Write then read, requester 1, top address
    enq(1, 1'b1, 1'b0, 6'h3F, 32'h1234_5678);
    enq(1, 1'b0, 1'b1, 6'h3F, 32'd0);
    wait_resp(3, 80, "t2");
    chk("t2_grant", 64'(last_g), 64'd1);
    chk("t2_data", 64'(last_data), 64'h1234_5678);
    chk("t2_err", 64'(last_err), 64'd0);

    // Both requesters busy: strict alternation
    enq(0, 1'b0, 1'b1, 6'h01, 32'd0);
    enq(1, 1'b1, 1'b0, 6'h10, 32'hCAFE_0001);
    enq(0, 1'b0, 1'b1, 6'h02, 32'd0);
    enq(1, 1'b0, 1'b1, 6'h10, 32'd0);
    wait_resp(7, 120, "t3");
    chk("t3_g0", 64'(glog(3)), 64'd0);
    chk("t3_g1", 64'(glog(4)), 64'd1);
    chk("t3_g2", 64'(glog(5)), 64'd0);
    chk("t3_g3", 64'(glog(6)), 64'd1);
    chk("t3_last_data", 64'(last_data), 64'hCAFE_0001);

    // Slave never acks: timeout response, then a late ack while idle
    no_ack = 1'b1;
    enq(1, 1'b0, 1'b1, 6'h07, 32'd0);
    wait_resp(8, 60, "t4");
    chk("t4_grant", 64'(last_g), 64'd1);
    chk("t4_err", 64'(last_err), 64'd1);
    chk("t4_data", 64'(last_data), 64'd0);
    chk("t4_timeout_cycles", 64'(ack_edge - req_edge), 64'd16);
    no_ack = 1'b0;
    late_ack = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_late_ack_dropped", 64'(resp_count), 64'd8);
    enq(0, 1'b0, 1'b1, 6'h05, 32'd0);
    wait_resp(9, 50, "t4b");
    chk("t4b_data", 64'(last_data), 64'hDEAD_BEEF);
    chk("t4b_err", 64'(last_err), 64'd0);

    // Invalid command (both types) with the response held off
    s_ack_rdy = '0;
    mc = mreq_count;
    enq(0, 1'b1, 1'b1, 6'h09, 32'h5555_AAAA);
    n = 0;
    while (s_ack_vld == '0 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("t5_hold_vld", 64'(s_ack_vld), 64'h1);
    chk("t5_hold_err", 64'(s_err), 64'd1);
    s_ack_rdy = '1;
    wait_resp(10, 20, "t5");
    chk("t5_err", 64'(last_err), 64'd1);
    chk("t5_data", 64'(last_data), 64'd0);
    chk("t5_no_m_req", 64'(mreq_count), 64'(mc));
    chk("t5_immediate", 64'(ack_edge - acc_edge), 64'd0);

    // Reset while waiting for the downstream ack
    no_ack = 1'b1;
    mc = mreq_count;
    enq(1, 1'b0, 1'b1, 6'h02, 32'd0);
    n = 0;
    while (!(mreq_count > mc && !m_req_vld) && n < 20) begin @(negedge clk); n++; end
    chk("t6_reached_wait", 64'(mreq_count), 64'(mc + 1));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      drv_q[i].delete();
      mdl_q[i].delete();
    end
    #1;
    chk("t6_m_req_vld", 64'(m_req_vld), 64'd0);
    chk("t6_m_type", 64'({m_wr_en, m_rd_en}), 64'd0);
    chk("t6_m_addr", 64'(m_addr), 64'd0);
    chk("t6_s_ack_vld", 64'(s_ack_vld), 64'd0);
    chk("t6_s_err", 64'(s_err), 64'd0);
    chk("t6_s_rd_data", 64'(s_rd_data), 64'd0);
    chk("t6_m_ack_rdy", 64'(m_ack_rdy), 64'd1);
    repeat (3) @(negedge clk);
    chk("t6_no_resp", 64'(resp_count), 64'd10);
    rst = 1'b0;
    no_ack = 1'b0;
    @(negedge clk);
    enq(1, 1'b0, 1'b1, 6'h02, 32'd0);
    enq(0, 1'b0, 1'b1, 6'h01, 32'd0);
    wait_resp(12, 80, "t6b");
    chk("t6_first_grant", 64'(glog(10)), 64'd0);
    chk("t6_second_grant", 64'(glog(11)), 64'd1);
    chk("t6_last_data", 64'(last_data), 64'hA500_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
